// File: rtl/mrr_downlink_ook_tx.sv
// -----------------------------------------------------------------------------
// mrr_downlink_ook_tx
// Transmit side of the MRR link. Serialises a 32-bit downlink word into an
// on/off-keyed tx_en waveform that gates the interrogation carrier toward the
// retro-reflector tag. Each packet is framed as preamble -> payload -> recharge
// guard. A tx_disable abort is honoured in every active state. A running packet
// count is kept.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for i_tvalid & i_tready; tx_en low
// PREAMBLE | sending latched preamble bits MSB-first
// PAYLOAD  | sending latched payload bits MSB-first from bit 31
// GUARD    | tx_en low for recharge_len cycles (min 1); o_done on last
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_tdata/i_tvalid  downlink word and its valid
//   i_tready          word accepted when i_tvalid & i_tready
//   tx_disable        inhibit in IDLE, abort in any other state
//   symbol_len        cycles per bit (0 treated as 1)
//   preamble_pattern  preamble bits, MSB-first
//   preamble_len      preamble bits to send (clamped to PREAMBLE_WIDTH)
//   num_payload_bits  payload bits to send (clamped to 32)
//   recharge_len      guard cycles after payload
//   tx_en             OOK output, 1 = carrier on
//   o_busy            high outside IDLE
//   o_bit_strobe      pulse on first cycle of each bit
//   o_done            pulse on last GUARD cycle
//   o_abort           pulse when tx_disable kills a packet
//   o_packet_count    completed packets, wraps
// -----------------------------------------------------------------------------
module mrr_downlink_ook_tx #(
  parameter int SYM_LEN_WIDTH  = 16,
  parameter int PREAMBLE_WIDTH = 16,
  parameter int PACKET_INDEX   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               i_tdata,
  input  logic                      i_tvalid,
  output logic                      i_tready,
  input  logic                      tx_disable,
  input  logic [SYM_LEN_WIDTH-1:0]  symbol_len,
  input  logic [PREAMBLE_WIDTH-1:0] preamble_pattern,
  input  logic [4:0]                preamble_len,
  input  logic [7:0]                num_payload_bits,
  input  logic [14:0]               recharge_len,
  output logic                      tx_en,
  output logic                      o_busy,
  output logic                      o_bit_strobe,
  output logic                      o_done,
  output logic                      o_abort,
  output logic [PACKET_INDEX-1:0]   o_packet_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    GUARD    = 2'd3
  } state_t;

  localparam int PRE_MAX_INT = (PREAMBLE_WIDTH < 31) ? PREAMBLE_WIDTH : 31;
  localparam logic [5:0]               L_PRE_MAX = 6'(PRE_MAX_INT);
  localparam logic [5:0]               L_BIT_ONE = 6'd1;
  localparam logic [SYM_LEN_WIDTH-1:0] L_SYM_ONE = SYM_LEN_WIDTH'(1);
  localparam logic [14:0]              L_GRD_ONE = 15'd1;
  localparam logic [PACKET_INDEX-1:0]  L_CNT_ONE = PACKET_INDEX'(1);

  state_t                    r_state;
  logic [SYM_LEN_WIDTH-1:0]  r_sym_len;
  logic [SYM_LEN_WIDTH-1:0]  r_sym_cnt;
  logic [5:0]                r_bits_left;
  logic [5:0]                r_pay_bits;
  logic [14:0]               r_guard_len;
  logic [14:0]               r_guard_cnt;
  logic [PREAMBLE_WIDTH-1:0] r_pre_sr;
  logic [31:0]               r_pay_sr;

  logic                      w_accept;
  logic [5:0]                w_pre_bits;
  logic [5:0]                w_pay_bits;
  logic [SYM_LEN_WIDTH-1:0]  w_sym_len;
  logic [14:0]               w_glen;
  logic [14:0]               w_guard_load;
  logic                      w_guard_last;

  assign i_tready = (r_state == IDLE) & ~tx_disable & ~rst;
  assign w_accept = i_tvalid & i_tready;
  assign o_busy   = (r_state != IDLE);

  // Clamped view of the live settings; only used on the accept cycle.
  assign w_pre_bits = ({1'b0, preamble_len} > L_PRE_MAX) ? L_PRE_MAX : {1'b0, preamble_len};
  assign w_pay_bits = (num_payload_bits > 8'd32) ? 6'd32 : num_payload_bits[5:0];
  assign w_sym_len  = (symbol_len == '0) ? L_SYM_ONE : symbol_len;

  // Guard entry can happen straight from IDLE (empty packet), in which case the
  // latched copy is not yet valid and the live input is used instead.
  assign w_glen       = (r_state == IDLE) ? recharge_len : r_guard_len;
  assign w_guard_load = (w_glen == '0) ? '0 : (w_glen - L_GRD_ONE);
  assign w_guard_last = (w_glen <= L_GRD_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_sym_len      <= L_SYM_ONE;
      r_sym_cnt      <= '0;
      r_bits_left    <= '0;
      r_pay_bits     <= '0;
      r_guard_len    <= '0;
      r_guard_cnt    <= '0;
      r_pre_sr       <= '0;
      r_pay_sr       <= '0;
      tx_en          <= 1'b0;
      o_bit_strobe   <= 1'b0;
      o_done         <= 1'b0;
      o_abort        <= 1'b0;
      o_packet_count <= '0;
    end else begin
      o_bit_strobe <= 1'b0;
      o_done       <= 1'b0;
      o_abort      <= 1'b0;

      if ((r_state != IDLE) && tx_disable) begin
        r_state <= IDLE;
        tx_en   <= 1'b0;
        o_abort <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_sym_len   <= w_sym_len;
              r_pay_bits  <= w_pay_bits;
              r_guard_len <= recharge_len;
              r_sym_cnt   <= w_sym_len - L_SYM_ONE;
              if (w_pre_bits != '0) begin
                r_state      <= PREAMBLE;
                tx_en        <= preamble_pattern[PREAMBLE_WIDTH-1];
                r_pre_sr     <= {preamble_pattern[PREAMBLE_WIDTH-2:0], 1'b0};
                r_pay_sr     <= i_tdata;
                r_bits_left  <= w_pre_bits - L_BIT_ONE;
                o_bit_strobe <= 1'b1;
              end else if (w_pay_bits != '0) begin
                r_state      <= PAYLOAD;
                tx_en        <= i_tdata[31];
                r_pay_sr     <= {i_tdata[30:0], 1'b0};
                r_bits_left  <= w_pay_bits - L_BIT_ONE;
                o_bit_strobe <= 1'b1;
              end else begin
                r_state     <= GUARD;
                tx_en       <= 1'b0;
                r_guard_cnt <= w_guard_load;
                if (w_guard_last) begin
                  o_done         <= 1'b1;
                  o_packet_count <= o_packet_count + L_CNT_ONE;
                end
              end
            end
          end

          PREAMBLE: begin
            if (r_sym_cnt != '0) begin
              r_sym_cnt <= r_sym_cnt - L_SYM_ONE;
            end else if (r_bits_left != '0) begin
              tx_en        <= r_pre_sr[PREAMBLE_WIDTH-1];
              r_pre_sr     <= {r_pre_sr[PREAMBLE_WIDTH-2:0], 1'b0};
              r_bits_left  <= r_bits_left - L_BIT_ONE;
              r_sym_cnt    <= r_sym_len - L_SYM_ONE;
              o_bit_strobe <= 1'b1;
            end else if (r_pay_bits != '0) begin
              r_state      <= PAYLOAD;
              tx_en        <= r_pay_sr[31];
              r_pay_sr     <= {r_pay_sr[30:0], 1'b0};
              r_bits_left  <= r_pay_bits - L_BIT_ONE;
              r_sym_cnt    <= r_sym_len - L_SYM_ONE;
              o_bit_strobe <= 1'b1;
            end else begin
              r_state     <= GUARD;
              tx_en       <= 1'b0;
              r_guard_cnt <= w_guard_load;
              if (w_guard_last) begin
                o_done         <= 1'b1;
                o_packet_count <= o_packet_count + L_CNT_ONE;
              end
            end
          end

          PAYLOAD: begin
            if (r_sym_cnt != '0) begin
              r_sym_cnt <= r_sym_cnt - L_SYM_ONE;
            end else if (r_bits_left != '0) begin
              tx_en        <= r_pay_sr[31];
              r_pay_sr     <= {r_pay_sr[30:0], 1'b0};
              r_bits_left  <= r_bits_left - L_BIT_ONE;
              r_sym_cnt    <= r_sym_len - L_SYM_ONE;
              o_bit_strobe <= 1'b1;
            end else begin
              r_state     <= GUARD;
              tx_en       <= 1'b0;
              r_guard_cnt <= w_guard_load;
              if (w_guard_last) begin
                o_done         <= 1'b1;
                o_packet_count <= o_packet_count + L_CNT_ONE;
              end
            end
          end

          GUARD: begin
            tx_en <= 1'b0;
            if (r_guard_cnt != '0) begin
              r_guard_cnt <= r_guard_cnt - L_GRD_ONE;
              // o_done and the count land on the cycle where the counter reads 0.
              if (r_guard_cnt == L_GRD_ONE) begin
                o_done         <= 1'b1;
                o_packet_count <= o_packet_count + L_CNT_ONE;
              end
            end else begin
              r_state <= IDLE;
            end
          end

          default: begin
            r_state <= IDLE;
            tx_en   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mrr_downlink_ook_tx.sv
module tb_mrr_downlink_ook_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_tdata;
  logic        i_tvalid;
  logic        tx_disable;
  logic [15:0] symbol_len;
  logic [15:0] preamble_pattern;
  logic [4:0]  preamble_len;
  logic [7:0]  num_payload_bits;
  logic [14:0] recharge_len;

  logic       i_tready, tx_en, o_busy, o_bit_strobe, o_done, o_abort;
  logic [9:0] o_packet_count;

  logic       s_tready, s_tx_en, s_busy, s_strobe, s_done, s_abort;
  logic [1:0] s_count;

  int checks = 0;
  int errors = 0;
  int strobes;

  always #5 clk = ~clk;

  mrr_downlink_ook_tx dut (
    .clk(clk), .rst(rst), .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .tx_disable(tx_disable), .symbol_len(symbol_len), .preamble_pattern(preamble_pattern),
    .preamble_len(preamble_len), .num_payload_bits(num_payload_bits), .recharge_len(recharge_len),
    .tx_en(tx_en), .o_busy(o_busy), .o_bit_strobe(o_bit_strobe), .o_done(o_done),
    .o_abort(o_abort), .o_packet_count(o_packet_count)
  );

  // Narrow-counter instance sharing all stimulus, used for the wrap check.
  mrr_downlink_ook_tx #(.PACKET_INDEX(2)) dut_small (
    .clk(clk), .rst(rst), .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(s_tready),
    .tx_disable(tx_disable), .symbol_len(symbol_len), .preamble_pattern(preamble_pattern),
    .preamble_len(preamble_len), .num_payload_bits(num_payload_bits), .recharge_len(recharge_len),
    .tx_en(s_tx_en), .o_busy(s_busy), .o_bit_strobe(s_strobe), .o_done(s_done),
    .o_abort(s_abort), .o_packet_count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [15:0] sym, input logic [15:0] pat, input logic [4:0] plen,
                     input logic [31:0] word, input logic [7:0] pbits, input logic [14:0] rec);
    symbol_len       = sym;
    preamble_pattern = pat;
    preamble_len     = plen;
    i_tdata          = word;
    num_payload_bits = pbits;
    recharge_len     = rec;
  endtask

  // Called at a negedge with the settings applied; accepts one word and checks
  // every cycle from T+1 through the final guard cycle, then the idle cycle.
  task automatic send(input string tag, input int nbits, input logic [63:0] bits,
                      input int sym, input int gcyc, input bit mutate, output int nstb);
    int  total;
    logic exp_tx, exp_stb;
    total = nbits * sym + gcyc;
    nstb  = 0;
    chk({tag, "_ready_pre"}, {31'd0, i_tready}, 32'd1);
    i_tvalid = 1'b1;
    @(negedge clk);
    i_tvalid = 1'b0;
    if (mutate) cfg(16'd5, 16'h0000, 5'd1, 32'h8000_0000, 8'd1, 15'd0);
    for (int k = 1; k <= total; k++) begin
      if (k <= nbits * sym) begin
        exp_tx  = bits[nbits - 1 - (k - 1) / sym];
        exp_stb = ((k - 1) % sym) == 0;
      end else begin
        exp_tx  = 1'b0;
        exp_stb = 1'b0;
      end
      if (o_bit_strobe) nstb++;
      chk($sformatf("%s_tx_k%0d", tag, k),   {31'd0, tx_en},        {31'd0, exp_tx});
      chk($sformatf("%s_stb_k%0d", tag, k),  {31'd0, o_bit_strobe}, {31'd0, exp_stb});
      chk($sformatf("%s_done_k%0d", tag, k), {31'd0, o_done},       {31'd0, (k == total)});
      chk($sformatf("%s_busy_k%0d", tag, k), {31'd0, o_busy},       32'd1);
      chk($sformatf("%s_rdy_k%0d", tag, k),  {31'd0, i_tready},     32'd0);
      @(negedge clk);
    end
    chk({tag, "_busy_post"},  {31'd0, o_busy},   32'd0);
    chk({tag, "_done_post"},  {31'd0, o_done},   32'd0);
    chk({tag, "_ready_post"}, {31'd0, i_tready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] exp_small [5];
    exp_small = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst = 1'b1; i_tvalid = 1'b0; tx_disable = 1'b0;
    cfg(16'd3, 16'hA000, 5'd4, 32'hC300_0000, 8'd8, 15'd5);
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, i_tready},     32'd0);
    chk("rst_tx",    {31'd0, tx_en},        32'd0);
    chk("rst_busy",  {31'd0, o_busy},       32'd0);
    chk("rst_stb",   {31'd0, o_bit_strobe}, 32'd0);
    chk("rst_done",  {31'd0, o_done},       32'd0);
    chk("rst_abort", {31'd0, o_abort},      32'd0);
    chk("rst_count", {22'd0, o_packet_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame: preamble 1010, payload C3, 3 cycles/bit, 5 guard cycles.
    send("basic", 12, 64'b1010_1100_0011, 3, 5, 1'b0, strobes);
    chk("basic_strobes", strobes, 32'd12);
    chk("basic_count",   {22'd0, o_packet_count}, 32'd1);

    // Empty packet: single guard cycle.
    cfg(16'd0, 16'hFFFF, 5'd0, 32'hFFFF_FFFF, 8'd0, 15'd0);
    send("empty", 0, 64'd0, 1, 1, 1'b0, strobes);
    chk("empty_count", {22'd0, o_packet_count}, 32'd2);

    // Clamping: 20 preamble bits -> 16, 40 payload bits -> 32.
    cfg(16'd1, 16'hA5F0, 5'd20, 32'h1234_5678, 8'd40, 15'd0);
    send("clamp", 48, {16'hA5F0, 32'h1234_5678}, 1, 1, 1'b0, strobes);
    chk("clamp_strobes", strobes, 32'd48);
    chk("clamp_count",   {22'd0, o_packet_count}, 32'd3);

    // Abort during payload bit 5.
    cfg(16'd2, 16'h0000, 5'd0, 32'hFF00_0000, 8'd8, 15'd3);
    i_tvalid = 1'b1;
    @(negedge clk);
    i_tvalid = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_bit5_stb", {31'd0, o_bit_strobe}, 32'd1);
    chk("abort_bit5_tx",  {31'd0, tx_en},        32'd1);
    tx_disable = 1'b1;
    @(negedge clk);
    chk("abort_tx",    {31'd0, tx_en},    32'd0);
    chk("abort_pulse", {31'd0, o_abort},  32'd1);
    chk("abort_busy",  {31'd0, o_busy},   32'd0);
    chk("abort_done",  {31'd0, o_done},   32'd0);
    chk("abort_ready", {31'd0, i_tready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("abort_hold_pulse%0d", k), {31'd0, o_abort},  32'd0);
      chk($sformatf("abort_hold_ready%0d", k), {31'd0, i_tready}, 32'd0);
      chk($sformatf("abort_hold_done%0d", k),  {31'd0, o_done},   32'd0);
    end
    chk("abort_count", {22'd0, o_packet_count}, 32'd3);
    tx_disable = 1'b0;
    @(negedge clk);
    chk("abort_ready_back", {31'd0, i_tready}, 32'd1);

    // Reset mid-packet discards the packet and clears the count.
    cfg(16'd3, 16'hA000, 5'd4, 32'hC300_0000, 8'd8, 15'd5);
    i_tvalid = 1'b1;
    @(negedge clk);
    i_tvalid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", {31'd0, o_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",  {31'd0, o_busy},          32'd0);
    chk("midrst_tx",    {31'd0, tx_en},           32'd0);
    chk("midrst_count", {22'd0, o_packet_count},  32'd0);
    chk("midrst_scount", {30'd0, s_count},        32'd0);
    @(negedge clk);

    // Five back-to-back packets; narrow counter wraps 3 -> 0.
    cfg(16'd1, 16'h0000, 5'd0, 32'h8000_0000, 8'd1, 15'd1);
    i_tvalid = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 5; p++) begin
      n = 0;
      while (!o_done && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("b2b_done_seen%0d", p), {31'd0, o_done}, 32'd1);
      chk($sformatf("b2b_done_lat%0d", p), n, 32'd1);
      chk($sformatf("b2b_scount%0d", p), {30'd0, s_count}, {30'd0, exp_small[p]});
      chk($sformatf("b2b_count%0d", p), {22'd0, o_packet_count}, p + 1);
      @(negedge clk);
      chk($sformatf("b2b_ready%0d", p), {31'd0, i_tready}, 32'd1);
      if (p == 4) i_tvalid = 1'b0;
      @(negedge clk);
      if (p < 4) begin
        chk($sformatf("b2b_next_stb%0d", p), {31'd0, o_bit_strobe}, 32'd1);
        chk($sformatf("b2b_next_tx%0d", p),  {31'd0, tx_en},        32'd1);
      end
    end
    chk("b2b_idle_after", {31'd0, o_busy}, 32'd0);

    // Settings changed after accept do not affect the packet in flight.
    cfg(16'd2, 16'hC000, 5'd2, 32'h4000_0000, 8'd2, 15'd2);
    send("mut_cur", 4, 64'b1101, 2, 2, 1'b1, strobes);
    send("mut_next", 2, 64'b01, 5, 1, 1'b0, strobes);
    chk("mut_strobes", strobes, 32'd2);
    chk("mut_count",   {22'd0, o_packet_count}, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
